// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM chain: the dead-time stage state encoding,
// the default dead-time counter width and small helpers on the state type.
// No ports (package).
// ----------------------------------------------------------------------------
package pwm_pkg;

    // Default width of the dead-time count, in clk cycles.
    localparam int unsigned DtWDefault = 4;

    // Gate-drive stage states. Dead states keep both gates off.
    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StHsOn  = 3'd1,
        StDtH2l = 3'd2,
        StLsOn  = 3'd3,
        StDtL2h = 3'd4
    } pwm_state_e;

    // True for either dead-interval state.
    function automatic logic is_dead(input pwm_state_e st);
        return (st == StDtH2l) || (st == StDtL2h);
    endfunction

    // Dead state to enter when the command selects the given side.
    function automatic pwm_state_e dead_toward(input logic want_hs);
        return want_hs ? StDtL2h : StDtH2l;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// ----------------------------------------------------------------------------
// pwm_deadtime
// Converts a single PWM command into complementary high-side / low-side gate
// drives with a programmable dead interval between them, so the two gates
// are never on together.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   ena        in   block enable, 0 forces the safe (all-off) state
//   pwm_in     in   PWM command, 1 = high side, 0 = low side
//   dead_time  in   dead interval in clk cycles (0 behaves as 1)
//   kill       in   fault shutdown, highest priority after reset
//   hs_out     out  high-side gate drive (registered)
//   ls_out     out  low-side gate drive (registered)
//   dt_active  out  dead interval in progress (registered)
// ----------------------------------------------------------------------------
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DtWDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            kill,
    output logic            hs_out,
    output logic            ls_out,
    output logic            dt_active
);

    pwm_state_e      state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            hs_q, hs_d;
    logic            ls_q, ls_d;
    logic            dt_q, dt_d;

    // Counter load value is D-1 with D = max(dead_time, 1); the dead state
    // then exits on the edge where the counter is already zero, which gives
    // exactly D cycles in the dead state and never needs to count past zero.
    logic [DT_W-1:0] dt_load;
    assign dt_load = (dead_time == '0) ? '0 : (dead_time - DT_W'(1));

    // ------------------------------------------------------------------
    // State register (state, counter and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            dt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs_q    <= hs_d;
            ls_q    <= ls_d;
            dt_q    <= dt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (kill || !ena) begin
            // Safe state wins over everything, including a running interval.
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    // Leaving OFF always goes through a full dead interval.
                    state_d = dead_toward(pwm_in);
                    cnt_d   = dt_load;
                end
                StHsOn: begin
                    if (!pwm_in) begin
                        state_d = StDtH2l;
                        cnt_d   = dt_load;
                    end
                end
                StLsOn: begin
                    if (pwm_in) begin
                        state_d = StDtL2h;
                        cnt_d   = dt_load;
                    end
                end
                StDtH2l, StDtL2h: begin
                    // The exit side follows the command at the final edge,
                    // so an abandoned transition falls back after full D.
                    if (cnt_q == '0) begin
                        state_d = pwm_in ? StHsOn : StLsOn;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: outputs are decoded from the next state and registered,
    // so they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        hs_d = 1'b0;
        ls_d = 1'b0;
        dt_d = 1'b0;
        case (state_d)
            StHsOn:  hs_d = 1'b1;
            StLsOn:  ls_d = 1'b1;
            default: dt_d = is_dead(state_d);
        endcase
    end

    assign hs_out    = hs_q;
    assign ls_out    = ls_q;
    assign dt_active = dt_q;

endmodule
